// File: rtl/bias_vector_cache.sv
// Bias vector store: internal vectors served from local storage, one vector fetched from an
// external memory port. Define BVM_EXT_CACHE_EN to keep a valid-tagged copy of the external vector.
module bias_vector_cache #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned NUM_ELEMS   = 16,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned EXT_BASE    = 0,
    parameter int unsigned EXT_VECTOR  = 0,
    localparam int unsigned VI_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int unsigned EI_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clear,
    input  logic              req,
    input  logic [VI_W-1:0]   vector_index,
    input  logic [EI_W-1:0]   element_index,
    output logic              ext_req,
    output logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_valid,
    input  logic              wr_en,
    input  logic [VI_W-1:0]   wr_vector,
    input  logic [EI_W-1:0]   wr_element,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] b_element,
    output logic              b_element_ready,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIntRead, StExtWait} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   b_element_q, b_element_d;
    logic [ADDR_W-1:0]   ext_addr_q, ext_addr_d;

    logic [DATA_W-1:0]   mem [NUM_VECTORS][NUM_ELEMS];
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   cache_rd;
    logic                in_range;
    logic                is_ext;
    logic                hit;
    logic                wr_ok;
    logic                accept_ext;
    logic                fill;

    assign in_range = (32'(vector_index) < NUM_VECTORS) && (32'(element_index) < NUM_ELEMS);
    assign is_ext   = (vector_index == VI_W'(EXT_VECTOR));
    assign rd_data  = mem[vector_index][element_index];

    assign accept_ext = (state_q == StIdle) && en && req && in_range && is_ext && !hit;
    assign fill       = (state_q == StExtWait) && ext_valid;

    // The external vector's row is never written; its data only ever comes from the port.
    assign wr_ok = wr_en && (32'(wr_vector) < NUM_VECTORS) && (32'(wr_element) < NUM_ELEMS)
                   && (wr_vector != VI_W'(EXT_VECTOR));

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_vector][wr_element] <= wr_data;
        end
    end

`ifdef BVM_EXT_CACHE_EN
    logic [DATA_W-1:0]    cache_q [NUM_ELEMS];
    logic [NUM_ELEMS-1:0] valid_q;
    logic [EI_W-1:0]      fetch_elem_q;

    assign hit      = in_range && is_ext && valid_q[element_index];
    assign cache_rd = cache_q[element_index];

    // Clear beats a coinciding fill so the entry stays invalid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q      <= '0;
            fetch_elem_q <= '0;
        end else begin
            if (accept_ext) begin
                fetch_elem_q <= element_index;
            end
            if (clear) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[fetch_elem_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fill) begin
            cache_q[fetch_elem_q] <= ext_data;
        end
    end
`else
    logic unused_clear;

    assign hit          = 1'b0;
    assign cache_rd     = '0;
    assign unused_clear = clear;
`endif

    always_comb begin
        state_d     = state_q;
        b_element_d = b_element_q;
        ext_addr_d  = ext_addr_q;
        unique case (state_q)
            StIdle: begin
                if (en && req) begin
                    if (!in_range) begin
                        b_element_d = '0;
                        state_d     = StIntRead;
                    end else if (accept_ext) begin
                        ext_addr_d = ADDR_W'(EXT_BASE) + ADDR_W'(element_index);
                        state_d    = StExtWait;
                    end else begin
                        b_element_d = hit ? cache_rd : rd_data;
                        state_d     = StIntRead;
                    end
                end
            end
            StIntRead: state_d = StIdle;
            StExtWait: begin
                if (ext_valid) begin
                    b_element_d = ext_data;
                    state_d     = StIntRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            b_element_q <= '0;
            ext_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            b_element_q <= b_element_d;
            ext_addr_q  <= ext_addr_d;
        end
    end

    assign ext_req         = (state_q == StExtWait);
    assign ext_addr        = ext_addr_q;
    assign b_element       = b_element_q;
    assign b_element_ready = (state_q == StIntRead);
    assign busy            = (state_q != StIdle);

endmodule
